sa_pe_pipe: RTL and testbench

SA_PE_PIPE -- requirements
Module: sa_pe_pipe

---
 rtl/matrix_cps_pkg.sv | 61 ++++++
 rtl/mac_int_pipe.sv | 95 +++++++++
 rtl/sa_pe_pipe.sv | 86 ++++++++
 tb/tb_sa_pe_pipe.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_cps_pkg.sv
// Shared types, limits and the per-lane integer MAC rule for the systolic-array PEs.
package matrix_cps_pkg;

  localparam int MAC_LATENCY_MAX = 4;
  localparam int LANE_WIDTH      = 32;

  typedef enum logic [1:0] {
    DT_INT32 = 2'd0,
    DT_INT16 = 2'd1,
    DT_INT8  = 2'd2
  } datatype_e;

  typedef struct packed {
    datatype_e datatype;
    logic      is_float;
  } sa_ctrl_t;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } pe_state_e;

  // Two guard bits hold acc plus up to two full 32-bit products without overflow.
  localparam logic signed [33:0] SUM_MAX = 34'sh0_7FFF_FFFF;
  localparam logic signed [33:0] SUM_MIN = 34'sh3_8000_0000;

  function automatic logic [31:0] lane_mac(input logic [31:0] acc,
                                           input logic [31:0] data,
                                           input logic [31:0] weight,
                                           input datatype_e   dt,
                                           input logic        saturate);
    logic signed [33:0] term;
    logic signed [33:0] sum;
    logic signed [31:0] p32;
    logic signed [15:0] p8;
    term = '0;
    case (dt)
      DT_INT8: begin
        for (int i = 0; i < 4; i++) begin
          p8   = 16'($signed(data[8*i +: 8])) * 16'($signed(weight[8*i +: 8]));
          term = term + 34'(p8);
        end
      end
      DT_INT16: begin
        for (int i = 0; i < 2; i++) begin
          p32  = 32'($signed(data[16*i +: 16])) * 32'($signed(weight[16*i +: 16]));
          term = term + 34'(p32);
        end
      end
      default: begin
        p32  = data * weight;
        term = 34'(p32);
      end
    endcase
    sum = 34'($signed(acc)) + term;
    if (saturate && (sum > SUM_MAX)) return 32'h7FFF_FFFF;
    if (saturate && (sum < SUM_MIN)) return 32'h8000_0000;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/mac_int_pipe.sv
// SIMD integer MAC delayed through MAC_LATENCY register stages, with a matching valid pipe.
module mac_int_pipe
  import matrix_cps_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAC_LATENCY = 2,
  parameter int ENABLE_SIMD = 1,
  parameter int SATURATE    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush,
  input  logic                  valid,
  input  sa_ctrl_t              ctrl,
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [DATA_WIDTH-1:0] weight,
  output logic                  done,
  output logic                  unsupported,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;

  datatype_e             eff_dt;
  logic [DATA_WIDTH-1:0] mac_res;
  logic [DATA_WIDTH-1:0] fin_res;
  logic                  fin_vld;
  logic                  fin_unsup;

  assign eff_dt = (ENABLE_SIMD != 0) ? ctrl.datatype : DT_INT32;

  // Float ops are not computed here: the accumulator passes through untouched.
  always_comb begin
    mac_res = '0;
    for (int l = 0; l < LANES; l++) begin
      mac_res[LANE_WIDTH*l +: LANE_WIDTH] = ctrl.is_float
        ? acc[LANE_WIDTH*l +: LANE_WIDTH]
        : lane_mac(acc[LANE_WIDTH*l +: LANE_WIDTH], data[LANE_WIDTH*l +: LANE_WIDTH],
                   weight[LANE_WIDTH*l +: LANE_WIDTH], eff_dt, SATURATE != 0);
    end
  end

  if (MAC_LATENCY == 1) begin : g_direct
    assign fin_res   = mac_res;
    assign fin_vld   = valid;
    assign fin_unsup = valid & ctrl.is_float;
  end else begin : g_stages
    localparam int N = MAC_LATENCY - 1;

    logic [N-1:0]          vld;
    logic [N-1:0]          unsup;
    logic [DATA_WIDTH-1:0] res [N];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld   <= '0;
        unsup <= '0;
      end else if (flush) begin
        vld   <= '0;
        unsup <= '0;
      end else begin
        vld   <= N'({vld, valid});
        unsup <= N'({unsup, valid & ctrl.is_float});
      end
    end

    // NOTE: data stages have no reset; a stage is only consumed when its valid bit is set.
    always_ff @(posedge clk_i) begin
      res[0] <= mac_res;
      for (int i = 1; i < N; i++) res[i] <= res[i-1];
    end

    assign fin_res   = res[N-1];
    assign fin_vld   = vld[N-1];
    assign fin_unsup = unsup[N-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done        <= 1'b0;
      unsupported <= 1'b0;
      result      <= '0;
    end else if (flush) begin
      done        <= 1'b0;
      unsupported <= 1'b0;
      result      <= '0;
    end else begin
      done        <= fin_vld;
      unsupported <= fin_unsup;
      if (fin_vld) result <= fin_res;
    end
  end

endmodule

// File: rtl/sa_pe_pipe.sv
// Systolic-array PE: pump handshake FSM and latency counter around the pipelined SIMD MAC.
module sa_pe_pipe
  import matrix_cps_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAC_LATENCY = 2,
  parameter int ENABLE_SIMD = 1,
  parameter int SATURATE    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  pump_i,
  output logic                  pump_ready_o,
  input  logic                  flush_i,
  input  sa_ctrl_t              sa_ctrl_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [DATA_WIDTH-1:0] weight_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [DATA_WIDTH-1:0] acc_o,
  output sa_ctrl_t              sa_ctrl_o,
  output logic                  pump_done_o,
  output logic                  unsupported_o
);

  localparam int              CNT_W    = $clog2(MAC_LATENCY_MAX);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAC_LATENCY - 1);

  pe_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // Ready in the last cycle of an op lets a new pump overlap its completion.
  assign pump_ready_o = !flush_i && ((state == ST_IDLE) || (cnt == '0));
  assign accept       = pump_i && pump_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      data_o    <= '0;
      sa_ctrl_o <= '0;
    end else if (flush_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      if (accept) begin
        data_o    <= data_i;
        sa_ctrl_o <= sa_ctrl_i;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state <= ST_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        default: begin
          if (cnt != '0)   cnt   <= cnt - 1'b1;
          else if (accept) cnt   <= CNT_LOAD;
          else             state <= ST_IDLE;
        end
      endcase
    end
  end

  mac_int_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAC_LATENCY(MAC_LATENCY),
    .ENABLE_SIMD(ENABLE_SIMD),
    .SATURATE   (SATURATE)
  ) u_mac (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush      (flush_i),
    .valid      (accept),
    .ctrl       (sa_ctrl_i),
    .acc        (acc_i),
    .data       (data_i),
    .weight     (weight_i),
    .done       (pump_done_o),
    .unsupported(unsupported_o),
    .result     (acc_o)
  );

endmodule

// File: tb/tb_sa_pe_pipe.sv
// Bench for sa_pe_pipe: four parameter sets, each driven by directed and random pumps against a lane-arithmetic model.
module tb_sa_pe_pipe;
  import matrix_cps_pkg::*;

  int total     = 0;
  int bad       = 0;
  int cfg_done  = 0;
  logic clk_i   = 1'b0;

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          due;
    logic [63:0] val;
    bit          unsup;
  } pend_t;

  localparam sa_ctrl_t C_I32 = '{DT_INT32, 1'b0};
  localparam sa_ctrl_t C_I8  = '{DT_INT8,  1'b0};
  localparam sa_ctrl_t C_FLT = '{DT_INT16, 1'b1};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Low w bits of v read as a two's-complement number.
  function automatic longint sext(input longint v, input int w);
    longint m;
    m = longint'(1) <<< w;
    v = v & (m - 1);
    if (v >= (m >>> 1)) v = v - m;
    return v;
  endfunction

  function automatic logic [63:0] model_mac(input int w, input bit simd, input bit sat,
                                            input sa_ctrl_t c, input logic [63:0] acc,
                                            input logic [63:0] dat, input logic [63:0] wt);
    logic [63:0] r;
    int n;
    int ew;
    r = '0;
    if (c.is_float) return acc;
    n  = !simd ? 1 : (c.datatype == DT_INT8) ? 4 : (c.datatype == DT_INT16) ? 2 : 1;
    ew = 32 / n;
    for (int l = 0; l < w / 32; l++) begin
      longint a, dl, wl, term, sum, p;
      a    = sext(longint'(acc >> (32 * l)), 32);
      dl   = longint'(dat >> (32 * l));
      wl   = longint'(wt >> (32 * l));
      term = 0;
      for (int i = 0; i < n; i++) begin
        p = sext(dl >>> (ew * i), ew) * sext(wl >>> (ew * i), ew);
        if (n == 1) p = sext(p, 32);
        term += p;
      end
      sum = a + term;
      if (sat && sum > 64'sd2147483647)  sum = 64'sd2147483647;
      if (sat && sum < -64'sd2147483648) sum = -64'sd2147483648;
      r[32*l +: 32] = 32'(sum);
    end
    return r;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int LAT  = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;
    localparam int SAT  = (g == 1 || g == 3) ? 1 : 0;
    localparam int SIMD = (g == 3) ? 0 : 1;
    localparam int W    = (g == 1) ? 64 : 32;
    localparam logic [63:0] MASK = (W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;

    logic         rst_ni;
    logic         pump_i;
    logic         pump_ready_o;
    logic         flush_i;
    sa_ctrl_t     sa_ctrl_i;
    sa_ctrl_t     sa_ctrl_o;
    logic [W-1:0] acc_i;
    logic [W-1:0] data_i;
    logic [W-1:0] weight_i;
    logic [W-1:0] data_o;
    logic [W-1:0] acc_o;
    logic         pump_done_o;
    logic         unsupported_o;

    sa_pe_pipe #(
      .DATA_WIDTH (W),
      .MAC_LATENCY(LAT),
      .ENABLE_SIMD(SIMD),
      .SATURATE   (SAT)
    ) u_dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .pump_i       (pump_i),
      .pump_ready_o (pump_ready_o),
      .flush_i      (flush_i),
      .sa_ctrl_i    (sa_ctrl_i),
      .acc_i        (acc_i),
      .data_i       (data_i),
      .weight_i     (weight_i),
      .data_o       (data_o),
      .acc_o        (acc_o),
      .sa_ctrl_o    (sa_ctrl_o),
      .pump_done_o  (pump_done_o),
      .unsupported_o(unsupported_o)
    );

    pend_t       pend[$];
    logic [63:0] e_acc   = '0;
    logic [63:0] e_data  = '0;
    sa_ctrl_t    e_ctrl  = '0;
    bit          e_done  = 1'b0;
    bit          e_unsup = 1'b0;
    int          cyc        = 0;
    int          ready_from = 0;

    function automatic string tag(input string s);
      return $sformatf("cfg%0d_%s", g, s);
    endfunction

    // One cycle: drive, compare every output with the model, then advance the model.
    task automatic step(input bit p, input bit f, input sa_ctrl_t c,
                        input logic [63:0] a, input logic [63:0] d, input logic [63:0] wt);
      bit m_ready;
      @(negedge clk_i);
      pump_i    = p;
      flush_i   = f;
      sa_ctrl_i = c;
      acc_i     = a[W-1:0];
      data_i    = d[W-1:0];
      weight_i  = wt[W-1:0];
      #1;
      m_ready = !f && (cyc >= ready_from);
      check(tag("acc_o"),         64'(acc_o),         e_acc);
      check(tag("data_o"),        64'(data_o),        e_data);
      check(tag("sa_ctrl_o"),     64'(sa_ctrl_o),     64'(e_ctrl));
      check(tag("pump_done_o"),   64'(pump_done_o),   64'(e_done));
      check(tag("unsupported_o"), 64'(unsupported_o), 64'(e_unsup));
      check(tag("pump_ready_o"),  64'(pump_ready_o),  64'(m_ready));
      if (f) begin
        pend.delete();
        e_acc      = '0;
        e_done     = 1'b0;
        e_unsup    = 1'b0;
        ready_from = cyc + 1;
      end else begin
        if (p && m_ready) begin
          pend.push_back('{cyc + LAT,
                           model_mac(W, SIMD != 0, SAT != 0, c, a & MASK, d & MASK, wt & MASK),
                           c.is_float});
          e_data     = d & MASK;
          e_ctrl     = c;
          ready_from = cyc + LAT;
        end
        e_done  = 1'b0;
        e_unsup = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc + 1) begin
          e_acc   = pend[0].val;
          e_done  = 1'b1;
          e_unsup = pend[0].unsup;
          void'(pend.pop_front());
        end
      end
      cyc++;
    endtask

    task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    // Pump once and wait until the cycle its result must be visible.
    task automatic run_op(input sa_ctrl_t c, input logic [63:0] a, input logic [63:0] d,
                          input logic [63:0] wt);
      step(1'b1, 1'b0, c, a, d, wt);
      idle(LAT);
    endtask

    task automatic do_reset(input int hold);
      @(negedge clk_i);
      rst_ni  = 1'b0;
      pump_i  = 1'b0;
      flush_i = 1'b0;
      #1;
      check(tag("rst_acc_o"),         64'(acc_o),         '0);
      check(tag("rst_data_o"),        64'(data_o),        '0);
      check(tag("rst_sa_ctrl_o"),     64'(sa_ctrl_o),     '0);
      check(tag("rst_pump_done_o"),   64'(pump_done_o),   '0);
      check(tag("rst_unsupported_o"), 64'(unsupported_o), '0);
      check(tag("rst_pump_ready_o"),  64'(pump_ready_o),  64'd1);
      repeat (hold) @(negedge clk_i);
      rst_ni = 1'b1;
      pend.delete();
      e_acc      = '0;
      e_data     = '0;
      e_ctrl     = '0;
      e_done     = 1'b0;
      e_unsup    = 1'b0;
      cyc        = cyc + hold + 1;
      ready_from = cyc;
    endtask

    initial begin
      rst_ni    = 1'b0;
      pump_i    = 1'b0;
      flush_i   = 1'b0;
      sa_ctrl_i = '0;
      acc_i     = '0;
      data_i    = '0;
      weight_i  = '0;
      do_reset(2);
      idle(10);

      if (g == 0) begin
        step(1'b1, 1'b0, C_I32, 64'd10, 64'd3, 64'd4);
        idle(1);
        check(tag("lit_busy_not_ready"), 64'(pump_ready_o), 64'd0);
        idle(1);
        check(tag("lit_int32_done"), 64'(pump_done_o), 64'd1);
        check(tag("lit_int32_acc"),  64'(acc_o),       64'd22);
        run_op(C_I8, 64'd0, 64'h0102_0304, 64'h0101_0101);
        check(tag("lit_int8_acc"), 64'(acc_o), 64'd10);
        run_op(C_I8, 64'd0, 64'hFFFF_FFFF, 64'h0101_0101);
        check(tag("lit_int8_neg_acc"), 64'(acc_o), 64'hFFFF_FFFC);
        run_op(C_I32, 64'hFFFF_FFFF, 64'd1, 64'd1);
        check(tag("lit_wrap_acc"), 64'(acc_o), 64'd0);
        run_op(C_FLT, 64'h1234_5678, 64'd5, 64'd6);
        check(tag("lit_float_unsup"), 64'(unsupported_o), 64'd1);
        check(tag("lit_float_acc"),   64'(acc_o),         64'h1234_5678);
        step(1'b1, 1'b0, C_I32, 64'd7, 64'd7, 64'd7);
        do_reset(1);
        idle(6);
      end else if (g == 1) begin
        step(1'b1, 1'b0, C_I32, 64'd5, 64'd5, 64'd5);
        step(1'b0, 1'b1, '0, '0, '0, '0);
        idle(1);
        check(tag("lit_flush_acc"),   64'(acc_o),        64'd0);
        check(tag("lit_flush_ready"), 64'(pump_ready_o), 64'd1);
        check(tag("lit_flush_done"),  64'(pump_done_o),  64'd0);
        idle(4);
        run_op(C_I32, 64'h8000_0000_7FFF_FFFF, 64'hFFFF_FFFF_0000_0001, 64'h0000_0001_0000_0001);
        check(tag("lit_sat_acc"), 64'(acc_o), 64'h8000_0000_7FFF_FFFF);
      end else if (g == 2) begin
        for (int i = 0; i < 4; i++) begin
          step(1'b1, 1'b0, C_I32, 64'(i), 64'd1, 64'd1);
          if (i > 0) check(tag($sformatf("lit_b2b_acc%0d", i)), 64'(acc_o), 64'(i));
        end
        idle(1);
        check(tag("lit_b2b_acc4"), 64'(acc_o), 64'd4);
      end else begin
        run_op(C_I8, 64'd0, 64'h0102_0304, 64'h0101_0101);
        check(tag("lit_nosimd_acc"), 64'(acc_o), 64'h0A09_0704);
      end

      for (int i = 0; i < 300; i++) begin
        sa_ctrl_t    c;
        logic [63:0] a, d, wt;
        int          k;
        c.datatype = datatype_e'($urandom_range(2, 0));
        c.is_float = ($urandom_range(9, 0) == 0);
        a  = {$urandom, $urandom};
        d  = {$urandom, $urandom};
        wt = {$urandom, $urandom};
        k  = $urandom_range(3, 0);
        if (k == 0) a = {2{32'h7FFF_FFF0}};
        else if (k == 1) a = {2{32'h8000_0010}};
        step($urandom_range(9, 0) < 6, $urandom_range(29, 0) == 0, c, a, d, wt);
      end
      idle(LAT + 1);
      cfg_done++;
    end
  end

  initial begin
    check("model_int32",    model_mac(32, 1, 0, C_I32, 64'd10, 64'd3, 64'd4), 64'd22);
    check("model_int8",     model_mac(32, 1, 0, C_I8, 64'd0, 64'h0102_0304, 64'h0101_0101), 64'd10);
    check("model_int8_neg", model_mac(32, 1, 0, C_I8, 64'd0, 64'hFFFF_FFFF, 64'h0101_0101), 64'hFFFF_FFFC);
    check("model_wrap",     model_mac(32, 1, 0, C_I32, 64'hFFFF_FFFF, 64'd1, 64'd1), 64'd0);
    check("model_sat",      model_mac(32, 1, 1, C_I32, 64'h7FFF_FFFF, 64'd1, 64'd1), 64'h7FFF_FFFF);
    for (int t = 0; t < 20000 && cfg_done < 4; t++) @(posedge clk_i);
    check("all_cfg_done", 64'(cfg_done), 64'd4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
